jtag_scan_sequencer: RTL and testbench
======================================

Name: jtag_scan_sequencer

Overview:
- Command-driven JTAG master that sequences a TAP controller (16-state IEEE 1149.1 FSM, 4-bit encoding 0=TEST_LOGIC_RESET … 15=UPDATE_IR).
- Accepts IR-scan, DR-scan, reset and idle commands, generates the TMS/TDI stream, captures TDO and returns the shifted-out data.
- Keeps an internal mirror of the attached TAP state. Sits between the debug host logic and the TAP pins.

Parameters:
- DATA_W, 32, max scan length in bits and width of cmd_data/rsp_data.
- LEN_W, 6, width of cmd_len; must hold values 0..DATA_W.

Ports:
- tck  in  1  test clock; single clock domain, all logic on rising edge.
- trst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_type  in  2  00 RESET, 01 IR_SCAN, 10 DR_SCAN, 11 IDLE.
- cmd_len  in  LEN_W  scan length in bits (scans) or RTI cycle count (IDLE).
- cmd_data  in  DATA_W  TDI bits, LSB shifted first.
- tdo  in  1  TAP serial output.
- tms  out  1  TAP mode select (registered).
- tdi  out  1  TAP serial input (registered).
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  DATA_W  captured TDO bits, right-aligned, upper bits zero.
- rsp_err  out  1  qualifies rsp_valid; illegal command.
- tap_state  out  4  mirrored TAP state, same 0..15 encoding.

Behaviour:
- Timing model:
  - tms/tdi are registered.
  - Values driven in cycle k are sampled by the TAP, and by tap_state, at the rising edge ending cycle k.
  - tdo is sampled on that same edge.
- Reset (trst=1 at an edge): tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0, tap_state=TEST_LOGIC_RESET, FSM=INIT.
  - Reset mid-command abandons the command; no rsp_valid is produced.
- INIT: drive tms=1 for 5 cycles, then tms=0 for 1 cycle. This reaches RUN_TEST_IDLE regardless of the TAP's prior state. Then go to IDLE.
- IDLE:
  - tap_state=RUN_TEST_IDLE, tms=0, tdi=0, cmd_ready=1.
  - Accept on cmd_valid && cmd_ready. Latch type, len and data. cmd_ready drops the next cycle.
- RESET command: tms = 1,1,1,1,1,0 (6 cycles), then return to IDLE.
- IR_SCAN: tms = 1,1,0,0 (Select-DR, Select-IR, Capture-IR → Shift-IR), then len shift cycles, then tms = 1,0.
  - Total len+6 cycles.
- DR_SCAN: tms = 1,0,0, then len shift cycles, then tms = 1,0.
  - Total len+5 cycles.
- Shift cycles (tap_state=SHIFT_xR):
  - tdi = data bit i for i = 0..len-1.
  - tms=0, except tms=1 on bit len-1 (exit to EXIT1_xR).
  - The tdo sampled at shift i is written to rsp_data[i]. Bits ≥len are zero.
  - Path Exit1 → Update → RTI; Pause states are never entered.
  - tdi=0 outside shift cycles.
- IDLE command: tms=0 for len cycles in RUN_TEST_IDLE. len=0 completes immediately.
- Completion:
  - On the first cycle back in IDLE: rsp_valid=1 for exactly 1 cycle and cmd_ready=1 in the same cycle.
  - A new command may be accepted in that cycle.
  - rsp_data holds until the next completion.
- Illegal scan (len=0 or len>DATA_W):
  - No TMS activity.
  - The next cycle gives rsp_valid=1, rsp_err=1, rsp_data=0.
  - tap_state remains RUN_TEST_IDLE.
- RESET and IDLE commands return rsp_data=0 and rsp_err=0.
- tap_state always equals the next-state function of the TAP FSM applied to the previous tap_state and tms.
  - This holds as an invariant, including during INIT.
- cmd_data and cmd_type are ignored when not accepted. Changes after acceptance have no effect.

Test Plan:
- trst pulse, then release:
  - tms = 1×5, then 0.
  - tap_state TLR → RTI.
  - cmd_ready rises on cycle 7 after release.
  - No rsp_valid.
- IR_SCAN, len=4, data=0xA, tdo tied to tdi:
  - tms = 1,1,0,0,0,0,0,1,1,0.
  - tdi during shift = 0,1,0,1.
  - rsp_data=0x0000000A, rsp_err=0.
- DR_SCAN, len=32, data=0xA5A5_00FF, tdo driven from a 0xDEADBEEF pattern (LSB first):
  - 37-cycle sequence.
  - rsp_data=0xDEADBEEF.
  - tap_state passes through CAPTURE_DR, SHIFT_DR, EXIT1_DR, UPDATE_DR.
- Back-to-back: DR_SCAN len=1 with cmd_valid held, then IDLE len=3:
  - Second command accepted in the rsp_valid cycle.
  - 3 RTI cycles with tms=0, then rsp_valid.
- DR_SCAN len=0, and separately len=33:
  - rsp_valid and rsp_err both high on the next cycle.
  - tms stays 0; tap_state=RTI.
- trst asserted mid-DR shift, bit 5 of len 16:
  - Outputs return to reset values the next cycle.
  - INIT sequence runs.
  - No rsp_valid for the aborted command.

Source files
------------

// File: rtl/jtag_scan_sequencer.sv
// rtl/jtag_scan_sequencer.sv - command-driven JTAG TAP scan sequencer
//
// Ports:
//   tck, trst           clock, synchronous active-high reset
//   cmd_valid/ready     command handshake; cmd_type, cmd_len, cmd_data latched on accept
//   tdo                 TAP serial output, sampled on every rising edge
//   tms, tdi            registered TAP pin drive
//   rsp_valid           one-cycle completion pulse with rsp_data / rsp_err
//   tap_state           mirror of the attached TAP controller state

module jtag_scan_sequencer #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 6
) (
    input  logic              tck,
    input  logic              trst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_type,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              tdo,
    output logic              tms,
    output logic              tdi,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [3:0]        tap_state
);

    localparam logic [3:0] TAP_TLR      = 4'd0;
    localparam logic [3:0] TAP_RTI      = 4'd1;
    localparam logic [3:0] TAP_SEL_DR   = 4'd2;
    localparam logic [3:0] TAP_CAP_DR   = 4'd3;
    localparam logic [3:0] TAP_SHIFT_DR = 4'd4;
    localparam logic [3:0] TAP_EXIT1_DR = 4'd5;
    localparam logic [3:0] TAP_PAUSE_DR = 4'd6;
    localparam logic [3:0] TAP_EXIT2_DR = 4'd7;
    localparam logic [3:0] TAP_UPD_DR   = 4'd8;
    localparam logic [3:0] TAP_SEL_IR   = 4'd9;
    localparam logic [3:0] TAP_CAP_IR   = 4'd10;
    localparam logic [3:0] TAP_SHIFT_IR = 4'd11;
    localparam logic [3:0] TAP_EXIT1_IR = 4'd12;
    localparam logic [3:0] TAP_PAUSE_IR = 4'd13;
    localparam logic [3:0] TAP_EXIT2_IR = 4'd14;
    localparam logic [3:0] TAP_UPD_IR   = 4'd15;

    localparam logic [1:0] CMD_RESET = 2'b00;
    localparam logic [1:0] CMD_IR    = 2'b01;
    localparam logic [1:0] CMD_DR    = 2'b10;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_PRE,
        ST_SHIFT,
        ST_POST,
        ST_RUN,
        ST_TRES
    } seq_e;

    seq_e              state;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  len_q;
    logic [DATA_W-1:0] sr;
    logic [DATA_W-1:0] cap;
    logic              is_ir;

    // IEEE 1149.1 TAP controller next-state function
    function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
        case (s)
            TAP_TLR:      tap_next = m ? TAP_TLR      : TAP_RTI;
            TAP_RTI:      tap_next = m ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_DR:   tap_next = m ? TAP_SEL_IR   : TAP_CAP_DR;
            TAP_CAP_DR:   tap_next = m ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_SHIFT_DR: tap_next = m ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_EXIT1_DR: tap_next = m ? TAP_UPD_DR   : TAP_PAUSE_DR;
            TAP_PAUSE_DR: tap_next = m ? TAP_EXIT2_DR : TAP_PAUSE_DR;
            TAP_EXIT2_DR: tap_next = m ? TAP_UPD_DR   : TAP_SHIFT_DR;
            TAP_UPD_DR:   tap_next = m ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_IR:   tap_next = m ? TAP_TLR      : TAP_CAP_IR;
            TAP_CAP_IR:   tap_next = m ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_SHIFT_IR: tap_next = m ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_EXIT1_IR: tap_next = m ? TAP_UPD_IR   : TAP_PAUSE_IR;
            TAP_PAUSE_IR: tap_next = m ? TAP_EXIT2_IR : TAP_PAUSE_IR;
            TAP_EXIT2_IR: tap_next = m ? TAP_UPD_IR   : TAP_SHIFT_IR;
            TAP_UPD_IR:   tap_next = m ? TAP_SEL_DR   : TAP_RTI;
            default:      tap_next = TAP_TLR;
        endcase
    endfunction

    // tms/tdi hold the value for the coming cycle; cnt counts cycles of the
    // current phase already completed at the edge being processed.
    always_ff @(posedge tck) begin
        if (trst) begin
            state     <= ST_INIT;
            cnt       <= '0;
            len_q     <= '0;
            sr        <= '0;
            cap       <= '0;
            is_ir     <= 1'b0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            tap_state <= TAP_TLR;
        end else begin
            tap_state <= tap_next(tap_state, tms);
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;

            case (state)
                // five tms=1 cycles then one tms=0 lands in RTI from any state
                ST_INIT, ST_TRES: begin
                    if (cnt == LEN_W'(5)) begin
                        cnt       <= '0;
                        tms       <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                        if (state == ST_TRES) begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= '0;
                        end
                    end else begin
                        cnt <= cnt + LEN_W'(1);
                        tms <= (cnt < LEN_W'(4));
                    end
                end

                ST_IDLE: begin
                    tms <= 1'b0;
                    tdi <= 1'b0;
                    if (cmd_valid) begin
                        len_q <= cmd_len;
                        sr    <= cmd_data;
                        cap   <= '0;
                        cnt   <= '0;
                        is_ir <= (cmd_type == CMD_IR);
                        case (cmd_type)
                            CMD_RESET: begin
                                tms       <= 1'b1;
                                cmd_ready <= 1'b0;
                                state     <= ST_TRES;
                            end
                            CMD_IR, CMD_DR: begin
                                if ((cmd_len == '0) || (cmd_len > LEN_W'(DATA_W))) begin
                                    // rejected in place: no TMS activity, stay ready
                                    rsp_valid <= 1'b1;
                                    rsp_err   <= 1'b1;
                                    rsp_data  <= '0;
                                end else begin
                                    tms       <= 1'b1;
                                    cmd_ready <= 1'b0;
                                    state     <= ST_PRE;
                                end
                            end
                            default: begin
                                if (cmd_len == '0) begin
                                    rsp_valid <= 1'b1;
                                    rsp_data  <= '0;
                                end else begin
                                    cmd_ready <= 1'b0;
                                    state     <= ST_RUN;
                                end
                            end
                        endcase
                    end
                end

                // walk RTI -> Select-DR [-> Select-IR] -> Capture -> Shift
                ST_PRE: begin
                    if (cnt == (is_ir ? LEN_W'(3) : LEN_W'(2))) begin
                        cnt   <= '0;
                        tms   <= (len_q == LEN_W'(1));
                        tdi   <= sr[0];
                        sr    <= sr >> 1;
                        state <= ST_SHIFT;
                    end else begin
                        cnt <= cnt + LEN_W'(1);
                        tms <= is_ir && (cnt == '0);
                    end
                end

                ST_SHIFT: begin
                    cap <= cap | (DATA_W'(tdo) << cnt);
                    if (cnt + LEN_W'(1) == len_q) begin
                        cnt   <= '0;
                        tms   <= 1'b1;
                        tdi   <= 1'b0;
                        state <= ST_POST;
                    end else begin
                        cnt <= cnt + LEN_W'(1);
                        tms <= (cnt + LEN_W'(2) == len_q);
                        tdi <= sr[0];
                        sr  <= sr >> 1;
                    end
                end

                // Exit1 -> Update -> RTI
                ST_POST: begin
                    if (cnt == '0) begin
                        cnt <= LEN_W'(1);
                        tms <= 1'b0;
                    end else begin
                        cnt       <= '0;
                        cmd_ready <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_data  <= cap;
                        state     <= ST_IDLE;
                    end
                end

                ST_RUN: begin
                    if (cnt + LEN_W'(1) == len_q) begin
                        cnt       <= '0;
                        cmd_ready <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_data  <= '0;
                        state     <= ST_IDLE;
                    end else begin
                        cnt <= cnt + LEN_W'(1);
                    end
                end

                default: begin
                    cnt       <= '0;
                    tms       <= 1'b1;
                    tdi       <= 1'b0;
                    cmd_ready <= 1'b0;
                    state     <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// tb/tb_jtag_scan_sequencer.sv - self-checking bench for jtag_scan_sequencer

module tb_jtag_scan_sequencer;

    logic        tck;
    logic        trst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [5:0]  cmd_len;
    logic [31:0] cmd_data;
    logic        tdo;
    logic        tms;
    logic        tdi;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [3:0]  tap_state;

    jtag_scan_sequencer #(.DATA_W(32), .LEN_W(6)) dut (
        .tck(tck), .trst(trst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .tdo(tdo), .tms(tms), .tdi(tdi),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .tap_state(tap_state)
    );

    initial begin
        tck = 1'b0;
        forever #5 tck = ~tck;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int nxt0[16];
    int nxt1[16];
    int q_tms[$];
    int q_tdi[$];
    int q_idx[$];
    logic        exp_tms, exp_tdi, exp_ready, exp_valid, exp_err;
    logic [31:0] exp_data;
    logic [31:0] cap;
    int          exp_state;
    int          cur_idx = -1;
    int          busy    = 0;     // 0 none, 1 power-up init, 2 command in flight
    bit          scan_cmd;
    bit          started = 0;

    task automatic push(input int m, input int d, input int i);
        q_tms.push_back(m);
        q_tdi.push_back(d);
        q_idx.push_back(i);
    endtask

    always @(posedge tck) begin : model
        int l;
        if (trst) begin
            started   = 1;
            exp_tms   = 1; exp_tdi = 0; exp_ready = 0; exp_valid = 0; exp_err = 0;
            exp_data  = 0; exp_state = 0; cur_idx = -1;
            q_tms.delete(); q_tdi.delete(); q_idx.delete();
            for (int i = 0; i < 5; i++) push(i < 4, 0, -1);
            busy = 1;
        end else if (started) begin
            exp_state = exp_tms ? nxt1[exp_state] : nxt0[exp_state];
            if (cur_idx >= 0) cap[cur_idx] = tdo;
            exp_valid = 0; exp_err = 0; cur_idx = -1; exp_tms = 0; exp_tdi = 0;
            if (q_tms.size() == 0 && busy == 0 && exp_ready && cmd_valid) begin
                l = int'(cmd_len);
                case (cmd_type)
                    2'b00: begin
                        for (int i = 0; i < 6; i++) push(i < 5, 0, -1);
                        busy = 2; scan_cmd = 0;
                    end
                    2'b01, 2'b10: begin
                        if (l == 0 || l > 32) begin
                            exp_valid = 1; exp_err = 1; exp_data = 0;
                        end else begin
                            push(1, 0, -1);
                            if (cmd_type == 2'b01) push(1, 0, -1);
                            push(0, 0, -1);
                            push(0, 0, -1);
                            for (int i = 0; i < l; i++) push(i == l - 1, cmd_data[i], i);
                            push(1, 0, -1);
                            push(0, 0, -1);
                            busy = 2; scan_cmd = 1; cap = 0;
                        end
                    end
                    default: begin
                        if (l == 0) begin
                            exp_valid = 1; exp_data = 0;
                        end else begin
                            for (int i = 0; i < l; i++) push(0, 0, -1);
                            busy = 2; scan_cmd = 0;
                        end
                    end
                endcase
            end
            if (q_tms.size() > 0) begin
                exp_tms   = 1'(q_tms.pop_front());
                exp_tdi   = 1'(q_tdi.pop_front());
                cur_idx   = q_idx.pop_front();
                exp_ready = 0;
            end else begin
                exp_ready = 1;
                if (busy == 2) begin
                    exp_valid = 1;
                    exp_data  = scan_cmd ? cap : 32'd0;
                end
                busy = 0;
            end
        end
    end

    // per-cycle comparison against the model
    initial forever begin
        @(negedge tck);
        if (started) begin
            chk("tms", tms, exp_tms);
            chk("tdi", tdi, exp_tdi);
            chk("cmd_ready", cmd_ready, exp_ready);
            chk("rsp_valid", rsp_valid, exp_valid);
            chk("rsp_err", rsp_err, exp_err);
            chk("rsp_data", rsp_data, exp_data);
            chk("tap_state", tap_state, 32'(exp_state));
        end
    end

    // tdo source: 0 = looped from tdi, 1 = pattern by shift index, 2 = random
    int          mode = 2;
    logic [31:0] pat  = 0;
    initial forever begin
        @(negedge tck);
        case (mode)
            0:       tdo = tdi;
            1:       tdo = (cur_idx >= 0 && cur_idx < 32) ? pat[cur_idx] : 1'b0;
            default: tdo = 1'($urandom);
        endcase
    end

    // ---------------- stimulus helpers ----------------
    bit seen[16];

    task automatic issue(input logic [1:0] t, input int l, input logic [31:0] d, input bit hold);
        int n;
        cmd_type = t; cmd_len = l[5:0]; cmd_data = d; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 500) begin
            @(negedge tck);
            n++;
        end
        if (n >= 500) chk("issue_timeout", 32'(n), 0);
        @(negedge tck);
        if (!hold) begin
            cmd_valid = 1'b0;
            cmd_type  = 2'($urandom);
            cmd_len   = 6'($urandom);
            cmd_data  = $urandom;
        end
    endtask

    task automatic run_until_rsp(output logic [31:0] d, output logic e, output int cycles,
                                 output logic [63:0] tms_tr, output logic [63:0] tdi_tr);
        cycles = 0; tms_tr = '0; tdi_tr = '0;
        while (!rsp_valid && cycles < 300) begin
            if (cycles < 64) begin
                tms_tr[cycles] = tms;
                tdi_tr[cycles] = tdi;
            end
            seen[tap_state] = 1'b1;
            @(negedge tck);
            cycles++;
        end
        if (cycles >= 300) chk("rsp_timeout", 32'(cycles), 0);
        d = rsp_data;
        e = rsp_err;
    endtask

    task automatic count_init(output int n, output int rv, output logic [63:0] tr);
        n = 1; rv = 0; tr = '0;
        while (n < 30) begin
            if (n <= 6) tr[n-1] = tms;
            if (rsp_valid) rv++;
            if (cmd_ready) break;
            @(negedge tck);
            n++;
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] d;
        logic        e;
        int          c, n, rv;
        logic [63:0] tt, dt;

        nxt0 = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
        nxt1 = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
        trst = 1'b1; cmd_valid = 1'b0; cmd_type = 2'b00; cmd_len = '0; cmd_data = '0; tdo = 1'b0;

        // power-up INIT
        repeat (3) @(negedge tck);
        trst = 1'b0;
        count_init(n, rv, tt);
        chk("init_ready_cycle", 32'(n), 7);
        chk("init_tms_seq", tt[5:0], 6'h1F);
        chk("init_tap_rti", tap_state, 1);
        chk("init_no_rsp", 32'(rv), 0);

        // IR scan, tdo looped back from tdi
        mode = 0;
        issue(2'b01, 4, 32'hA, 0);
        run_until_rsp(d, e, c, tt, dt);
        chk("ir_cycles", 32'(c), 10);
        chk("ir_tms_seq", tt[9:0], 10'h183);
        chk("ir_tdi_seq", dt[9:0], 10'h0A0);
        chk("ir_rsp_data", d, 32'h0000000A);
        chk("ir_rsp_err", e, 0);

        // full-width DR scan, patterned tdo
        mode = 1; pat = 32'hDEADBEEF;
        foreach (seen[i]) seen[i] = 1'b0;
        issue(2'b10, 32, 32'hA5A500FF, 0);
        run_until_rsp(d, e, c, tt, dt);
        chk("dr32_cycles", 32'(c), 37);
        chk("dr32_rsp_data", d, 32'hDEADBEEF);
        chk("dr32_path", {seen[3], seen[4], seen[5], seen[8], seen[6], seen[13]}, 6'b111100);

        // illegal lengths
        issue(2'b10, 0, 32'h1234, 0);
        chk("len0_valid_err", {rsp_valid, rsp_err, tms}, 3'b110);
        chk("len0_data", rsp_data, 0);
        chk("len0_tap", tap_state, 1);
        @(negedge tck);
        chk("len0_one_pulse", rsp_valid, 0);
        issue(2'b01, 33, 32'h5678, 0);
        chk("len33_valid_err", {rsp_valid, rsp_err, tms}, 3'b110);
        chk("len33_tap", tap_state, 1);

        // back-to-back with cmd_valid held
        mode = 2;
        issue(2'b10, 1, 32'h1, 1);
        cmd_type = 2'b11; cmd_len = 6'd3; cmd_data = 32'hFFFF_FFFF;
        run_until_rsp(d, e, c, tt, dt);
        chk("b2b_dr_cycles", 32'(c), 6);
        chk("b2b_ready_in_rsp", cmd_ready, 1);
        @(negedge tck);
        cmd_valid = 1'b0;
        run_until_rsp(d, e, c, tt, dt);
        chk("b2b_idle_cycles", 32'(c), 3);
        chk("b2b_idle_tms", tt[2:0], 3'b000);
        chk("b2b_idle_data", {e, d}, 33'h0);

        // reset in the middle of a DR shift
        mode = 1; pat = 32'h0000_00FF;
        issue(2'b10, 8, 32'h3C, 0);
        run_until_rsp(d, e, c, tt, dt);
        chk("pre_abort_data", d, 32'h0000_00FF);
        mode = 2;
        issue(2'b10, 16, $urandom, 0);
        n = 0;
        while (cur_idx != 5 && n < 100) begin
            @(negedge tck);
            n++;
        end
        if (n >= 100) chk("abort_reach_bit5", 32'(n), 0);
        trst = 1'b1;
        @(negedge tck);
        trst = 1'b0;
        chk("abort_reset_outs", {tms, tdi, cmd_ready, rsp_valid, rsp_err}, 5'b10000);
        chk("abort_reset_tap", tap_state, 0);
        chk("abort_reset_data", rsp_data, 0);
        count_init(n, rv, tt);
        chk("abort_ready_cycle", 32'(n), 7);
        chk("abort_no_rsp", 32'(rv), 0);

        // randomized traffic
        for (int it = 0; it < 300; it++) begin
            logic [1:0] t;
            int         l;
            t = 2'($urandom);
            case ($urandom_range(0, 9))
                0:       l = 0;
                1:       l = $urandom_range(33, 63);
                default: l = (t == 2'b11) ? $urandom_range(0, 8) : $urandom_range(1, 32);
            endcase
            issue(t, l, $urandom, 0);
            if (it == 150) begin
                repeat ($urandom_range(0, 5)) @(negedge tck);
                trst = 1'b1;
                @(negedge tck);
                trst = 1'b0;
            end else if ($urandom_range(0, 1) == 1) begin
                run_until_rsp(d, e, c, tt, dt);
            end else begin
                repeat ($urandom_range(0, 2)) @(negedge tck);
            end
        end
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge tck);
            n++;
        end
        repeat (4) @(negedge tck);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
